uart_tx_arb: RTL
================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 102, clocks per UART bit (9600 baud at the divided ~0.98 MHz chip clock); legal range >= 2.
REQ-002 clock  input  1  single chip clock; all state updates on its rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 req_valid  input  2  per-requester send request; bit i belongs to requester i.
REQ-005 req_data0 / req_data1  input  8 each  byte to send for requester 0 / 1; held stable while the matching req_valid is high.
REQ-006 req_ack  output  2  one-cycle pulse: byte of requester i accepted.
REQ-007 tx  output  1  UART serial line; idles high.
REQ-008 busy  output  1  high while a frame is in progress (any state other than IDLE).
REQ-009 grant_id  output  1  index of the most recently accepted requester.

Function
REQ-010 FSM states: IDLE, START, DATA, PARITY (only with UART_ARB_PARITY_EN), STOP.
REQ-011 IDLE with any req_valid high at a rising edge: latch the granted byte, set grant_id, enter START, and assert req_ack[grant] for exactly the next cycle.
REQ-012 Grant rule: only one valid bit set -> grant that requester; both set -> grant the requester named by the round-robin pointer.
REQ-013 After every grant, the pointer moves to the other requester.
REQ-014 req_valid is ignored outside IDLE; a request is never lost; it waits until it is acked.
REQ-015 Each bit lasts exactly CLKS_PER_BIT cycles; the bit counter is $clog2(CLKS_PER_BIT) bits wide and wraps to 0 at CLKS_PER_BIT-1.
REQ-016 Line levels per state: START drives tx=0; DATA sends the 8 bits LSB first; STOP drives tx=1; STOP then returns to IDLE.
REQ-017 tx is registered; tx falls in the same cycle that req_ack pulses.
REQ-018 Frame length: 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT cycles with parity.
REQ-019 At least one IDLE cycle separates frames.
REQ-020 busy is high from the first START cycle through the last STOP cycle.
REQ-021 Changes to req_data after its req_ack do not affect the frame in flight.

Reset
REQ-022 Reset values: tx=1, busy=0, req_ack=0, grant_id=0, state=IDLE, round-robin pointer=0, bit and baud counters=0.
REQ-023 Reset asserted mid-frame aborts the frame: tx=1 on the following cycle and no req_ack is issued.
REQ-024 Reset has priority over a simultaneous accept.

Configuration
REQ-025 Macro UART_ARB_PARITY_EN.
  - Defined: a PARITY state follows DATA and sends even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Undefined: DATA goes directly to STOP and no parity logic is synthesized.

Structure
REQ-026 Package uart_arb_pkg holds:
  - state enum uart_arb_state_t;
  - localparams DATA_BITS=8 and NUM_REQ=2;
  - the default CLKS_PER_BIT constant.
REQ-027 One sub-module, uart_baud_gen: counts CLKS_PER_BIT cycles, emits a one-cycle bit_done tick, and is cleared by the FSM on accept and by reset.
REQ-028 Arbitration and the shift register live in uart_tx_arb.

Verification (bench uses CLKS_PER_BIT=4)
REQ-029 Single request: req_valid=01, data0=0xA5.
  - req_ack=01 for 1 cycle.
  - tx = 0, 1,0,1,0,0,1,0,1, 1, each held 4 cycles; 40 cycles total.
  - busy high for all 40 cycles; grant_id=0.
REQ-030 Simultaneous requests: req_valid=11 after reset, data0=0x11, data1=0x22, both held until acked.
  - Frames go out in order 0x11, 0x22, 0x11, 0x22...
  - Each frame is separated by at least 1 idle cycle.
REQ-031 Held request: requester 1 asserts valid during requester 0's frame.
  - No ack for requester 1 mid-frame.
  - Requester 1 is acked in the first IDLE cycle after STOP.
REQ-032 Reset mid-frame: assert reset 13 cycles into a frame.
  - Next cycle: tx=1, busy=0, grant_id=0, state=IDLE.
  - The next simultaneous request grants requester 0.
REQ-033 Parity build with UART_ARB_PARITY_EN, data 0x07: bit 9 = 1, frame = 44 cycles.
REQ-034 Non-parity build, data 0x07: frame = 40 cycles, no parity bit.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the two-requester UART transmit arbiter.
package uart_arb_pkg;

  localparam int DATA_BITS            = 8;
  localparam int NUM_REQ              = 2;
  localparam int CLKS_PER_BIT_DEFAULT = 102;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_arb_state_t;

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester-side bus of the UART transmit arbiter: per-requester byte
// handshakes plus the serial line and status.
interface uart_tx_arb_if;
  import uart_arb_pkg::*;

  logic [NUM_REQ-1:0]   req_valid;
  logic [DATA_BITS-1:0] req_data0;
  logic [DATA_BITS-1:0] req_data1;
  logic [NUM_REQ-1:0]   req_ack;
  logic                 tx;
  logic                 busy;
  logic                 grant_id;

  modport master (
    output req_valid, req_data0, req_data1,
    input  req_ack, tx, busy, grant_id
  );

  modport slave (
    input  req_valid, req_data0, req_data1,
    output req_ack, tx, busy, grant_id
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts CLKS_PER_BIT enabled cycles and flags the last one.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 102
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic bit_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign bit_done = en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx_arb.sv
// Two-requester round-robin arbiter feeding an 8N1 UART transmitter.
// Define UART_ARB_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,
  uart_tx_arb_if.slave bus
);

  localparam logic [2:0] IDLE   = ST_IDLE;
  localparam logic [2:0] START  = ST_START;
  localparam logic [2:0] DATA   = ST_DATA;
`ifdef UART_ARB_PARITY_EN
  localparam logic [2:0] PARITY = ST_PARITY;
`endif
  localparam logic [2:0] STOP   = ST_STOP;

  localparam int BIT_CNT_W = $clog2(DATA_BITS);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

  logic [2:0]           state_q;
  logic                 rr_q;
  logic [NUM_REQ-1:0]   ack_q;
  logic                 gid_q;
  logic                 tx_q;
  logic [BIT_CNT_W-1:0] bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
`ifdef UART_ARB_PARITY_EN
  logic                 par_q;
`endif

  logic                 accept;
  logic                 gnt;
  logic [NUM_REQ-1:0]   gnt_onehot;
  logic [DATA_BITS-1:0] gnt_data;
  logic                 in_frame;
  logic                 bit_done;

  // Lone requester wins outright; a tie goes to the round-robin pointer.
  always_comb begin
    gnt = rr_q;
    if (bus.req_valid == 2'b01) begin
      gnt = 1'b0;
    end else if (bus.req_valid == 2'b10) begin
      gnt = 1'b1;
    end
  end

  assign gnt_onehot = gnt ? 2'b10 : 2'b01;
  assign gnt_data   = gnt ? bus.req_data1 : bus.req_data0;
  assign accept     = (state_q == IDLE) && (|bus.req_valid);
  assign in_frame   = (state_q != IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clock    (clock),
    .reset    (reset),
    .clr      (accept),
    .en       (in_frame),
    .bit_done (bit_done)
  );

  // Control path: state, handshake, grant bookkeeping and the line register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      tx_q      <= 1'b1;
      ack_q     <= '0;
      gid_q     <= 1'b0;
      rr_q      <= 1'b0;
      bit_cnt_q <= '0;
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q   <= START;
            tx_q      <= 1'b0;
            ack_q     <= gnt_onehot;
            gid_q     <= gnt;
            rr_q      <= ~gnt;
            bit_cnt_q <= '0;
          end
        end
        START: begin
          if (bit_done) begin
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end
        end
        DATA: begin
          if (bit_done) begin
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_q <= '0;
`ifdef UART_ARB_PARITY_EN
              state_q   <= PARITY;
              tx_q      <= par_q;
`else
              state_q   <= STOP;
              tx_q      <= 1'b1;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              tx_q      <= shift_q[0];
            end
          end
        end
`ifdef UART_ARB_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_done) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  // Data path: the granted byte is captured at accept so later edits by the
  // requester cannot disturb the frame; the shifter always exposes the next bit.
  always_ff @(posedge clock) begin
    if (accept) begin
      shift_q <= gnt_data;
`ifdef UART_ARB_PARITY_EN
      par_q   <= ^gnt_data;
`endif
    end else if (bit_done && (state_q == START || state_q == DATA)) begin
      shift_q <= shift_q >> 1;
    end
  end

  assign bus.req_ack  = ack_q;
  assign bus.tx       = tx_q;
  assign bus.busy     = in_frame;
  assign bus.grant_id = gid_q;

endmodule
